ctx_spill_fill: RTL
===================

CTX_SPILL_FILL -- requirements
Module: ctx_spill_fill

Interface
REQ-001 Parameter ADDR_STRIDE, default 4, byte distance between consecutive register slots in a memory context frame.
REQ-002 Parameter FIRST_REG, default 1, lowest architectural register moved; register 0 is never moved.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 exception_i  input  `XLEN  context exception code from the context buffer.
REQ-006 mscratch_addr_i  input  `XLEN  memory base of the incoming context.
REQ-007 spill_valid_i  input  1  victim context data valid, one cycle after the exception.
REQ-008 spill_data_i  input  `XLEN x [1:31]  victim registers 1..30; element 31 carries the victim memory base.
REQ-009 mem_req_o / mem_we_o  output  1 / 1  memory request and write-enable.
REQ-010 mem_addr_o / mem_wdata_o  output  `XLEN / `XLEN  request address and write data.
REQ-011 mem_ack_i / mem_rdata_i  input  1 / `XLEN  request accepted this cycle; read data valid with ack.
REQ-012 rf_we_o / rf_waddr_o / rf_wdata_o  output  1 / 5 / `XLEN  register-file write port for filled context.
REQ-013 busy_o  output  1  engine active; pipe control stalls on it.
REQ-014 done_o  output  1  one-cycle completion pulse.
REQ-015 spill_cnt_o / fill_cnt_o  output  32 / 32  completed-word counters, see Configuration.

Function
REQ-016 States SHALL be IDLE, WAIT_SPILL, SPILL, FILL, DONE.
REQ-017 In IDLE, code 2 SHALL go to FILL; codes 3, 4, 5 SHALL go to WAIT_SPILL; codes 0, 1 and any value >5 SHALL be ignored.
REQ-018 On leaving IDLE, the code and mscratch_addr_i SHALL be latched; exception_i is ignored in all other states.
REQ-019 WAIT_SPILL SHALL hold until spill_valid_i=1, latch spill_data_i[1:31] that cycle, then go to SPILL.
REQ-020 SPILL SHALL write registers 1..30 in ascending order to victim_base + i*ADDR_STRIDE, with victim_base = latched element 31.
REQ-021 After SPILL, code 4 SHALL go to FILL; codes 3 and 5 SHALL go to DONE.
REQ-022 FILL SHALL read registers 1..31 in ascending order from new_base + i*ADDR_STRIDE.
REQ-023 Address arithmetic SHALL be modulo 2^`XLEN, wrapping silently.
REQ-024 mem_req_o SHALL stay high, with address, data and we held stable, until mem_ack_i; at most one request outstanding; ack in the same cycle as req is legal.
REQ-025 Each fill ack SHALL produce rf_we_o=1 with rf_waddr_o=i and rf_wdata_o=mem_rdata_i in the following cycle, for exactly one cycle.
REQ-026 After the 31st fill ack, the FSM SHALL go to DONE. DONE lasts one cycle with done_o=1, then returns to IDLE.
REQ-027 busy_o SHALL be 1 in every non-IDLE state.
REQ-028 A code-4 sequence with zero-wait memory SHALL take exactly 64 cycles from the exception cycle T:
  - busy_o high T+1..T+63.
  - done_o high at T+63.

Reset
REQ-029 When rst_i is sampled high, in any state including mid-transfer, the FSM SHALL enter IDLE at the next edge.
REQ-030 During reset, all outputs SHALL be 0: mem_req_o, mem_we_o, rf_we_o, busy_o, done_o, addresses, data and counters.
REQ-031 A request pending at reset SHALL be dropped without waiting for ack.

Configuration
REQ-032 With CTX_SPILL_FILL_CNT_EN defined, spill_cnt_o and fill_cnt_o SHALL increment on each spill ack and each fill ack respectively, wrapping at 2^32.
REQ-033 Without CTX_SPILL_FILL_CNT_EN, both counter outputs SHALL be constant 0, with no counter flops.

Structure
REQ-034 Shared package ctx_pkg SHALL hold:
  - exception-code constants CTX_EXC_NONE/HIT/LW/SW/SWLW/SWONLY (0..5);
  - the state enum;
  - CTX_NREG=31.
REQ-035 One sub-module, ctx_spill_fill_perfcnt, SHALL hold the two counters; it is instantiated only under the macro.

Verification
REQ-036 Code 2, base 0x1000, zero-wait memory, mem_rdata = addr -> 31 reads at 0x1004..0x107C; rf writes x1..x31 = 0x1004..0x107C; done_o at T+32.
REQ-037 Code 4, victim base 0x2000, new base 0x3000 -> 30 writes at 0x2004..0x2078, then 31 reads at 0x3004..0x307C; done_o at T+63.
REQ-038 Code 5 with ack delayed 3 cycles per request -> each req held 4 cycles with stable address and data; no fill; done_o after 120 spill cycles.
REQ-039 rst_i asserted during the 10th spill write -> mem_req_o=0 and busy_o=0 the next cycle; a following code 2 starts cleanly.
REQ-040 Codes 0, 1, 6, and a second code 2 arriving while busy -> no memory traffic for those codes, busy_o unaffected.
REQ-041 With CTX_SPILL_FILL_CNT_EN, two code-4 runs -> spill_cnt_o=60, fill_cnt_o=62; without it, both read 0.

Source files
------------

// File: rtl/ctx_pkg.sv
// Shared constants, exception codes and FSM state type for the context spill/fill engine.
// Defines `XLEN as 32 when the build does not already provide it.
`ifndef XLEN
`define XLEN 32
`endif

package ctx_pkg;

    localparam int CTX_NREG = 31;

    localparam logic [`XLEN-1:0] CTX_EXC_NONE   = `XLEN'(0);
    localparam logic [`XLEN-1:0] CTX_EXC_HIT    = `XLEN'(1);
    localparam logic [`XLEN-1:0] CTX_EXC_LW     = `XLEN'(2);
    localparam logic [`XLEN-1:0] CTX_EXC_SW     = `XLEN'(3);
    localparam logic [`XLEN-1:0] CTX_EXC_SWLW   = `XLEN'(4);
    localparam logic [`XLEN-1:0] CTX_EXC_SWONLY = `XLEN'(5);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPILL,
        ST_SPILL,
        ST_FILL,
        ST_DONE
    } ctx_state_e;

endpackage

// File: rtl/ctx_spill_fill_perfcnt.sv
// Completed spill/fill word counters, wrapping at 2^32.
// Only built when CTX_SPILL_FILL_CNT_EN is defined.
`ifdef CTX_SPILL_FILL_CNT_EN
module ctx_spill_fill_perfcnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spill_ack_i,
    input  logic        fill_ack_i,
    output logic [31:0] spill_cnt_o,
    output logic [31:0] fill_cnt_o
);

    logic [31:0] spill_cnt_q, spill_cnt_d;
    logic [31:0] fill_cnt_q, fill_cnt_d;

    always_comb begin
        spill_cnt_d = spill_cnt_q + {31'd0, spill_ack_i};
        fill_cnt_d  = fill_cnt_q + {31'd0, fill_ack_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spill_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else begin
            spill_cnt_q <= spill_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
        end
    end

    assign spill_cnt_o = spill_cnt_q;
    assign fill_cnt_o  = fill_cnt_q;

endmodule
`endif

// File: rtl/ctx_spill_fill.sv
// Context spill/fill engine: spills victim registers to memory and fills a new context.
// Optional word counters are enabled with CTX_SPILL_FILL_CNT_EN.
`ifndef XLEN
`define XLEN 32
`endif

module ctx_spill_fill
    import ctx_pkg::*;
#(
    parameter int ADDR_STRIDE = 4,
    parameter int FIRST_REG   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [`XLEN-1:0] exception_i,
    input  logic [`XLEN-1:0] mscratch_addr_i,
    input  logic             spill_valid_i,
    input  logic [`XLEN-1:0] spill_data_i [1:CTX_NREG],
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [`XLEN-1:0] mem_addr_o,
    output logic [`XLEN-1:0] mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [`XLEN-1:0] mem_rdata_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [`XLEN-1:0] rf_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      spill_cnt_o,
    output logic [31:0]      fill_cnt_o
);

    localparam logic [4:0] FIRST_IDX  = 5'(FIRST_REG);
    localparam logic [4:0] LAST_SPILL = 5'(CTX_NREG - 1);
    localparam logic [4:0] LAST_FILL  = 5'(CTX_NREG);

    ctx_state_e       state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [`XLEN-1:0] code_q, code_d;
    logic [`XLEN-1:0] new_base_q, new_base_d;
    logic [`XLEN-1:0] spill_q [1:CTX_NREG];
    logic [`XLEN-1:0] spill_d [1:CTX_NREG];
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [`XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic             req, we, done;
    logic [`XLEN-1:0] addr, wdata, offset;
    logic [31:0]      spill_cnt, fill_cnt;

    assign offset = `XLEN'(idx_q) * `XLEN'(ADDR_STRIDE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        code_d     = code_q;
        new_base_d = new_base_q;
        spill_d    = spill_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        req        = 1'b0;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (1'b1)
                    (exception_i == CTX_EXC_LW): begin
                        state_d    = ST_FILL;
                        code_d     = exception_i;
                        new_base_d = mscratch_addr_i;
                        idx_d      = FIRST_IDX;
                    end
                    (exception_i == CTX_EXC_SW),
                    (exception_i == CTX_EXC_SWLW),
                    (exception_i == CTX_EXC_SWONLY): begin
                        state_d    = ST_WAIT_SPILL;
                        code_d     = exception_i;
                        new_base_d = mscratch_addr_i;
                    end
                    default: ;
                endcase
            end
            ST_WAIT_SPILL: begin
                if (spill_valid_i) begin
                    spill_d = spill_data_i;
                    idx_d   = FIRST_IDX;
                    state_d = ST_SPILL;
                end
            end
            ST_SPILL: begin
                // element CTX_NREG of the victim frame carries its memory base
                req   = 1'b1;
                we    = 1'b1;
                addr  = spill_q[CTX_NREG] + offset;
                wdata = spill_q[idx_q];
                if (mem_ack_i) begin
                    if (idx_q == LAST_SPILL) begin
                        idx_d   = FIRST_IDX;
                        state_d = (code_q == CTX_EXC_SWLW) ? ST_FILL : ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_FILL: begin
                req  = 1'b1;
                addr = new_base_q + offset;
                if (mem_ack_i) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = idx_q;
                    rf_wdata_d = mem_rdata_i;
                    if (idx_q == LAST_FILL) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            code_q     <= '0;
            new_base_q <= '0;
            spill_q    <= '{default: '0};
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            code_q     <= code_d;
            new_base_q <= new_base_d;
            spill_q    <= spill_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef CTX_SPILL_FILL_CNT_EN
    logic spill_ack, fill_ack;

    assign spill_ack = mem_ack_i & (state_q == ST_SPILL);
    assign fill_ack  = mem_ack_i & (state_q == ST_FILL);

    ctx_spill_fill_perfcnt u_perfcnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .spill_ack_i (spill_ack),
        .fill_ack_i  (fill_ack),
        .spill_cnt_o (spill_cnt),
        .fill_cnt_o  (fill_cnt)
    );
`else
    assign spill_cnt = '0;
    assign fill_cnt  = '0;
`endif

    // outputs are forced low while reset is asserted, dropping any pending request
    assign mem_req_o   = req & ~rst_i;
    assign mem_we_o    = we & ~rst_i;
    assign mem_addr_o  = rst_i ? '0 : addr;
    assign mem_wdata_o = rst_i ? '0 : wdata;
    assign rf_we_o     = rf_we_q & ~rst_i;
    assign rf_waddr_o  = rst_i ? '0 : rf_waddr_q;
    assign rf_wdata_o  = rst_i ? '0 : rf_wdata_q;
    assign busy_o      = (state_q != ST_IDLE) & ~rst_i;
    assign done_o      = done & ~rst_i;
    assign spill_cnt_o = rst_i ? '0 : spill_cnt;
    assign fill_cnt_o  = rst_i ? '0 : fill_cnt;

endmodule
